camera_stream_gen: RTL

//  Synthetic OV7670-style DVP pixel-stream transmitter: emits vsync/href/8-bit byte stream of RGB565 test

---
 rtl/camera_stream_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/camera_stream_gen.sv
// Synthetic DVP camera transmitter: vsync/href/byte stream of RGB565 test patterns,
// one byte per clk, high byte first; stands in for the sensor on the camera read path.
module camera_stream_gen #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_BLANK     = 288,
  parameter int          V_ACTIVE    = 480,
  parameter int          VSYNC_LINES = 3,
  parameter int          V_BACK      = 17,
  parameter int          V_FRONT     = 10,
  parameter logic [15:0] SOLID_COLOR = 16'hF800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] p_data,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int LINE_BYTES  = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_W         = $clog2(LINE_BYTES);
  localparam int V_W         = $clog2(FRAME_LINES);
  localparam int BAR_W       = H_ACTIVE / 8;

  localparam logic [H_W-1:0] H_LAST      = H_W'(LINE_BYTES - 1);
  localparam logic [H_W-1:0] H_ACT_BYTES = H_W'(2 * H_ACTIVE);
  localparam logic [V_W-1:0] V_LAST      = V_W'(FRAME_LINES - 1);
  localparam logic [V_W-1:0] V_SYNC_END  = V_W'(VSYNC_LINES);
  localparam logic [V_W-1:0] V_ACT_START = V_W'(VSYNC_LINES + V_BACK);
  localparam logic [V_W-1:0] V_ACT_LAST  = V_W'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     state_r, state_s;
  logic [H_W-1:0] h_cnt_r, h_cnt_s;
  logic [V_W-1:0] v_cnt_r, v_cnt_s;
  logic [1:0]     sel_r, sel_s;
  logic           vsync_r, href_r, done_r;
  logic [7:0]     data_r, count_r;
  logic           run_s, act_line_s, vsync_s, href_s, done_s, y3_s;
  logic [15:0]    x_s, pix_s;
  logic [7:0]     data_s;

  function automatic logic [15:0] pattern_pixel(input logic [1:0] sel, input logic [15:0] x,
                                                input logic y3);
    logic [2:0] bar;
    bar = 3'(x / 16'(BAR_W));
    case (sel)
      2'd0: pattern_pixel = SOLID_COLOR;
      2'd1: begin
        case (bar)
          3'd0:    pattern_pixel = 16'hFFFF;
          3'd1:    pattern_pixel = 16'hFFE0;
          3'd2:    pattern_pixel = 16'h07FF;
          3'd3:    pattern_pixel = 16'h07E0;
          3'd4:    pattern_pixel = 16'hF81F;
          3'd5:    pattern_pixel = 16'hF800;
          3'd6:    pattern_pixel = 16'h001F;
          default: pattern_pixel = 16'h0000;
        endcase
      end
      2'd2:    pattern_pixel = {x[7:3], x[7:2], x[7:3]};
      2'd3:    pattern_pixel = (x[3] ^ y3) ? 16'h0000 : 16'hFFFF;
      default: pattern_pixel = SOLID_COLOR;
    endcase
  endfunction

  // Next state: a frame, once started, always runs to its final byte
  always_comb begin
    state_s = state_r;
    h_cnt_s = h_cnt_r;
    v_cnt_s = v_cnt_r;
    sel_s   = sel_r;
    case (state_r)
      S_IDLE: begin
        h_cnt_s = {H_W{1'b0}};
        v_cnt_s = {V_W{1'b0}};
        if (enable) begin
          state_s = S_RUN;
          sel_s   = pattern_sel;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (h_cnt_r == H_LAST) begin
          h_cnt_s = {H_W{1'b0}};
          if (v_cnt_r == V_LAST) begin
            v_cnt_s = {V_W{1'b0}};
            if (enable) begin
              state_s = S_RUN;
              sel_s   = pattern_sel;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            v_cnt_s = v_cnt_r + 1'b1;
          end
        end else begin
          h_cnt_s = h_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
        h_cnt_s = {H_W{1'b0}};
        v_cnt_s = {V_W{1'b0}};
      end
    endcase
  end

  // Output decode from the current counters; registered below so all outputs move together
  always_comb begin
    run_s      = (state_r == S_RUN);
    act_line_s = (v_cnt_r >= V_ACT_START) && (v_cnt_r <= V_ACT_LAST);
    vsync_s    = run_s && (v_cnt_r < V_SYNC_END);
    href_s     = run_s && act_line_s && (h_cnt_r < H_ACT_BYTES);
    done_s     = run_s && (v_cnt_r == V_ACT_LAST) && (h_cnt_r == H_ACT_BYTES);
    x_s        = 16'(h_cnt_r >> 1);
    y3_s       = 1'((v_cnt_r - V_ACT_START) >> 3);
    pix_s      = pattern_pixel(sel_r, x_s, y3_s);
    if (!href_s) begin
      data_s = 8'h00;
    end else if (h_cnt_r[0]) begin
      data_s = pix_s[7:0];
    end else begin
      data_s = pix_s[15:8];
    end
  end

  // State, counters and latched pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      h_cnt_r <= {H_W{1'b0}};
      v_cnt_r <= {V_W{1'b0}};
      sel_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      h_cnt_r <= h_cnt_s;
      v_cnt_r <= v_cnt_s;
      sel_r   <= sel_s;
    end
  end

  // Registered stream outputs and completed-frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'h00;
      done_r  <= 1'b0;
      count_r <= 8'h00;
    end else begin
      vsync_r <= vsync_s;
      href_r  <= href_s;
      data_r  <= data_s;
      done_r  <= done_s;
      if (done_s) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign vsync       = vsync_r;
  assign href        = href_r;
  assign p_data      = data_r;
  assign frame_done  = done_r;
  assign frame_count = count_r;

endmodule
